// File: rtl/chaos_pkg.sv
// chaos_pkg: state word width, rotation amounts, FSM states and the
// keystream mix shared by the keystream extractor and its FIFO.
package chaos_pkg;

  localparam int STATE_W = 32;
  localparam int ROT_S   = 11;
  localparam int ROT_L   = 21;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    HALT   = 2'd3
  } state_e;

  // Folds one Xp/Xs/Xl triple into a keystream word: xp ^ rotl(xs,11) ^ rotl(xl,21)
  function automatic logic [STATE_W-1:0] chaos_mix(input logic [STATE_W-1:0] xp,
                                                   input logic [STATE_W-1:0] xs,
                                                   input logic [STATE_W-1:0] xl);
    logic [STATE_W-1:0] rot_s;
    logic [STATE_W-1:0] rot_l;
    rot_s = {xs[STATE_W-ROT_S-1:0], xs[STATE_W-1:STATE_W-ROT_S]};
    rot_l = {xl[STATE_W-ROT_L-1:0], xl[STATE_W-1:STATE_W-ROT_L]};
    return xp ^ rot_s ^ rot_l;
  endfunction

endpackage

// File: rtl/chaos_ks_fifo.sv
// chaos_ks_fifo: small synchronous word FIFO between the mix register and the
// byte serialiser. The head word is read in place (no output register), so a
// pop and a refill can happen in the same cycle. flush empties it at once.
module chaos_ks_fifo
  import chaos_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [STATE_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [STATE_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  logic [STATE_W-1:0] mem_q [DEPTH];
  logic [STATE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_wr, do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  // Pointer/count bookkeeping; a write into a full FIFO only lands when a read frees the slot
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control flops return to empty on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed while the count says it is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/chaos_keystream_extractor.sv
// chaos_keystream_extractor: discards the warm-up transient of the chaotic
// state generator, mixes each later Xp/Xs/Xl triple into a 32-bit word and
// serialises the words MSB-first as bytes on a valid/ready stream.
// Optional health monitor: define CHAOS_KS_HEALTH_EN to enable the stuck-orbit
// detector (stuck output, HALT state); undefined, stuck is tied low.
module chaos_keystream_extractor
  import chaos_pkg::*;
#(
  parameter int WARMUP_ITERS = 16,
  parameter int FIFO_DEPTH   = 2
`ifdef CHAOS_KS_HEALTH_EN
  , parameter int STUCK_LIMIT = 4
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [STATE_W-1:0] xp,
  input  logic [STATE_W-1:0] xs,
  input  logic [STATE_W-1:0] xl,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic [7:0]         ks_byte,
  output logic               warm_done,
  output logic               busy,
  output logic               stuck
);

  localparam int WARM_W = (WARMUP_ITERS > 1) ? $clog2(WARMUP_ITERS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic               mix_valid_q, mix_valid_d;
  logic [STATE_W-1:0] mix_q, mix_d;
  logic [1:0]         idx_q, idx_d;
  logic               accept, byte_take, fifo_rd;
  logic               fifo_full, fifo_empty;
  logic [STATE_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;

`ifdef CHAOS_KS_HEALTH_EN
  localparam int RUN_W = $clog2(STUCK_LIMIT) + 1;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               stuck_q, stuck_d;
  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  assign accept    = st_valid && st_ready;
  assign ks_valid  = !fifo_empty;
  assign byte_take = ks_valid && ks_ready;
  assign fifo_rd   = byte_take && (idx_q == 2'd3);
  assign warm_done = (state_q == RUN);
  assign busy      = (state_q != IDLE);

  // Triple acceptance: a word still in the mix register counts as occupying a FIFO slot
  always_comb begin
    st_ready = 1'b0;
    case (state_q)
      WARMUP:  st_ready = 1'b1;
      RUN:     st_ready = !fifo_full &&
                          !(mix_valid_q && (fifo_count == CNT_W'(FIFO_DEPTH - 1)));
      default: st_ready = 1'b0;
    endcase
  end

  // Serialiser view of the FIFO head word, most significant byte first
  always_comb begin
    ks_byte = 8'h00;
    if (ks_valid) begin
      case (idx_q)
        2'd0:    ks_byte = fifo_head[31:24];
        2'd1:    ks_byte = fifo_head[23:16];
        2'd2:    ks_byte = fifo_head[15:8];
        default: ks_byte = fifo_head[7:0];
      endcase
    end
  end

  // Next-state logic: FSM, warm-up count, mix stage, byte index and health check; stop wins last
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    mix_valid_d = 1'b0;
    mix_d       = mix_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = (WARMUP_ITERS == 0) ? RUN : WARMUP;
          warm_cnt_d = '0;
        end
      end
      WARMUP: begin
        if (accept) begin
          if (warm_cnt_q == WARM_W'(WARMUP_ITERS - 1)) begin
            state_d    = RUN;
            warm_cnt_d = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          mix_valid_d = 1'b1;
          mix_d       = chaos_mix(xp, xs, xl);
        end
      end
      default: ;
    endcase
    if (byte_take) begin
      idx_d = idx_q + 1'b1;
    end
`ifdef CHAOS_KS_HEALTH_EN
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    run_cnt_d    = run_cnt_q;
    stuck_d      = stuck_q;
    if (mix_valid_q) begin
      prev_d       = mix_q;
      prev_valid_d = 1'b1;
      if ((prev_valid_q && (mix_q == prev_q)) || (mix_q == '0)) begin
        if (run_cnt_q != RUN_W'(STUCK_LIMIT - 1)) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end else begin
        run_cnt_d = '0;
      end
      if (run_cnt_d == RUN_W'(STUCK_LIMIT - 1)) begin
        stuck_d = 1'b1;
        if (state_q == RUN) begin
          state_d = HALT;
        end
      end
    end
`endif
    if (stop) begin
      state_d     = IDLE;
      warm_cnt_d  = '0;
      mix_valid_d = 1'b0;
      idx_d       = '0;
`ifdef CHAOS_KS_HEALTH_EN
      prev_valid_d = 1'b0;
      run_cnt_d    = '0;
      stuck_d      = 1'b0;
`endif
    end
  end

  // All control state of the extractor, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      warm_cnt_q  <= '0;
      mix_valid_q <= 1'b0;
      mix_q       <= '0;
      idx_q       <= '0;
`ifdef CHAOS_KS_HEALTH_EN
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      run_cnt_q    <= '0;
      stuck_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      mix_valid_q <= mix_valid_d;
      mix_q       <= mix_d;
      idx_q       <= idx_d;
`ifdef CHAOS_KS_HEALTH_EN
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      run_cnt_q    <= run_cnt_d;
      stuck_q      <= stuck_d;
`endif
    end
  end

  chaos_ks_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (stop),
    .wr_en   (mix_valid_q),
    .wr_data (mix_q),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_chaos_keystream_extractor.sv
// tb_chaos_keystream_extractor: scoreboard bench for the keystream extractor.
// The stimulus side pushes expected bytes when a triple is accepted; a monitor
// on the falling edge pops and compares every byte handshake.
`timescale 1ns/1ps
module tb_chaos_keystream_extractor;

  logic        clk = 1'b0;
  logic        reset, start, stop, st_valid, st_ready, ks_valid, ks_ready;
  logic        warm_done, busy, stuck;
  logic [31:0] xp, xs, xl;
  logic [7:0]  ks_byte;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [7:0]  expQ[$];
  bit          modelArmed = 0;
  int          warmLeft   = 0;
  bit          holding    = 0;
  logic [7:0]  heldByte;

  localparam int WARMUP = 4;

  always #5 clk = ~clk;

  chaos_keystream_extractor #(
    .WARMUP_ITERS(WARMUP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .xp        (xp),
    .xs        (xs),
    .xl        (xl),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .ks_byte   (ks_byte),
    .warm_done (warm_done),
    .busy      (busy),
    .stuck     (stuck)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference mix: rotation taken as the upper half of a doubled word shifted left
  function automatic logic [31:0] refMix(input logic [31:0] p, input logic [31:0] s, input logic [31:0] l);
    logic [63:0] ds, dl;
    ds = {s, s} << 11;
    dl = {l, l} << 21;
    return p ^ ds[63:32] ^ dl[63:32];
  endfunction

  task automatic pushWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) expQ.push_back(8'(w >> (8 * i)));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One cycle of triple stimulus; on a handshake the model discards or queues the word
  task automatic applyStimulus(input bit v, input logic [31:0] p, input logic [31:0] s,
                               input logic [31:0] l, input logic [31:0] expWord, output bit acc);
    st_valid = v; xp = p; xs = s; xl = l;
    @(negedge clk);
    if (v && !modelArmed) checkOutput("st_ready_idle", 32'(st_ready), 0);
    acc = st_valid && st_ready;
    if (acc && modelArmed) begin
      if (warmLeft > 0) warmLeft--;
      else pushWord(expWord);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] p, input logic [31:0] s, input logic [31:0] l,
                          input logic [31:0] expWord);
    bit acc = 0;
    for (int i = 0; i < 64 && !acc; i++) applyStimulus(1'b1, p, s, l, expWord, acc);
    checkOutput("accept_in_time", 32'(acc), 1);
  endtask

  task automatic sendRandom();
    logic [31:0] p, s, l;
    p = $urandom; s = $urandom; l = $urandom;
    sendWord(p, s, l, refMix(p, s, l));
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
    modelArmed = 1;
    warmLeft   = WARMUP;
  endtask

  task automatic doStop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    expQ.delete();
    modelArmed = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_st_ready"}, 32'(st_ready), 0);
    checkOutput({tag, "_ks_valid"}, 32'(ks_valid), 0);
    checkOutput({tag, "_ks_byte"}, 32'(ks_byte), 0);
    checkOutput({tag, "_warm_done"}, 32'(warm_done), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_stuck"}, 32'(stuck), 0);
  endtask

  task automatic warmUp();
    pulseStart();
    checkOutput("start_busy", 32'(busy), 1);
    checkOutput("start_st_ready", 32'(st_ready), 1);
    for (int i = 0; i < WARMUP; i++) begin
      sendRandom();
      checkOutput("warm_done_track", 32'(warm_done), 32'(warmLeft == 0));
    end
  endtask

  task automatic drainAll();
    st_valid = 1'b0;
    ks_ready = 1'b1;
    for (int i = 0; i < 300 && expQ.size() != 0; i++) step();
    repeat (3) step();
    checkOutput("drain_queue_empty", 32'(expQ.size()), 0);
    checkOutput("drain_ks_valid_low", 32'(ks_valid), 0);
  endtask

  // Monitor: compares every taken byte against the scoreboard and checks that a stalled byte is held
  always @(negedge clk) begin
    if (reset || stop) begin
      holding = 0;
    end else begin
      if (holding) begin
        checkOutput("hold_valid", 32'(ks_valid), 1);
        checkOutput("hold_byte", 32'(ks_byte), 32'(heldByte));
      end
      if (ks_valid && ks_ready) begin
        holding = 0;
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_byte: got %0h, expected no byte", ks_byte);
        end else begin
          checkOutput("ks_byte", 32'(ks_byte), 32'(expQ.pop_front()));
        end
      end else if (ks_valid) begin
        holding  = 1;
        heldByte = ks_byte;
      end else begin
        holding = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accCount;
    bit acc;
    logic [31:0] p, s, l;
    reset = 1'b1; start = 1'b0; stop = 1'b0; st_valid = 1'b0; ks_ready = 1'b0;
    xp = '0; xs = '0; xl = '0;
    repeat (3) step();
    checkAllZero("in_reset");
    reset = 1'b0;
    step();
    checkAllZero("after_reset");

    // Warm-up discards four triples, then the first mixed word and its latency
    ks_ready = 1'b1;
    warmUp();
    repeat (3) step();
    checkOutput("warm_no_output", 32'(ks_valid), 0);
    sendWord(32'h01234567, 32'h0, 32'h0, 32'h01234567);
    checkOutput("latency_cycle1", 32'(ks_valid), 0);
    step();
    checkOutput("latency_cycle2", 32'(ks_valid), 1);
    sendWord(32'h0, 32'h1, 32'h0, 32'h00000800);
    sendWord(32'h0, 32'h0, 32'h1, 32'h00200000);
    sendWord(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drainAll();

    // Backpressure: only two words may be buffered, then eight gap-free bytes
    ks_ready = 1'b0;
    accCount = 0;
    for (int i = 0; i < 10; i++) begin
      p = $urandom; s = $urandom; l = $urandom;
      applyStimulus(1'b1, p, s, l, refMix(p, s, l), acc);
      if (acc) accCount++;
    end
    checkOutput("stall_accept_count", 32'(accCount), 2);
    checkOutput("stall_st_ready", 32'(st_ready), 0);
    checkOutput("stall_ks_valid", 32'(ks_valid), 1);
    ks_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("release_no_gap", 32'(ks_valid), 1);
      step();
    end
    checkOutput("release_done", 32'(ks_valid), 0);
    checkOutput("release_queue_empty", 32'(expQ.size()), 0);

    // Stop after two bytes of a word: remainder discarded, FSM idle
    sendRandom();
    for (int i = 0; i < 20 && !ks_valid; i++) step();
    checkOutput("stop_word_visible", 32'(ks_valid), 1);
    repeat (2) step();
    ks_ready = 1'b0;
    checkOutput("stop_bytes_left", 32'(expQ.size()), 2);
    doStop();
    checkOutput("stop_ks_valid", 32'(ks_valid), 0);
    checkOutput("stop_busy", 32'(busy), 0);
    checkOutput("stop_warm_done", 32'(warm_done), 0);
    checkOutput("stop_st_ready", 32'(st_ready), 0);
    ks_ready = 1'b1;
    applyStimulus(1'b1, 32'h1, 32'h2, 32'h3, 32'h0, acc);
    repeat (3) step();
    checkOutput("stop_fifo_empty", 32'(ks_valid), 0);

    // Restart repeats the warm-up, then randomized traffic against the model
    warmUp();
    for (int i = 0; i < 400; i++) begin
      ks_ready = ($urandom_range(0, 3) != 0);
      p = $urandom; s = $urandom; l = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), p, s, l, refMix(p, s, l), acc);
    end
    drainAll();

`ifdef CHAOS_KS_HEALTH_EN
    // Same triple four times trips the stuck detector; queued bytes still drain
    p = $urandom | 32'h1; s = $urandom; l = $urandom;
    for (int i = 0; i < 4; i++) sendWord(p, s, l, refMix(p, s, l));
    step();
    checkOutput("health_stuck", 32'(stuck), 1);
    checkOutput("health_st_ready", 32'(st_ready), 0);
    checkOutput("health_busy", 32'(busy), 1);
    drainAll();
    checkOutput("health_stuck_sticky", 32'(stuck), 1);
    doStop();
    checkOutput("health_stop_clears", 32'(stuck), 0);
    warmUp();
`endif

    // Reset in the middle of a stalled word clears every output
    ks_ready = 1'b0;
    sendRandom();
    repeat (2) step();
    checkOutput("pre_reset_ks_valid", 32'(ks_valid), 1);
    reset = 1'b1;
    step();
    checkAllZero("mid_run_reset");
    expQ.delete();
    modelArmed = 0;
    reset = 1'b0;
    repeat (2) step();
    checkOutput("post_reset_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
